// File: rtl/en_latch.sv
// ---------------------------------------------------------------------------
// en_latch
// Transparent-low D latch. This is the storage element of the clock gate. It
// is kept in its own module so that synthesis can map it to a library latch
// or ICG cell, and so that the intentional latch sits in one known place.
//
// Ports
//   d    in  1  data input (the gated enable)
//   g_n  in  1  active-low gate: transparent while 0, holds while 1
//   q    out 1  latch state
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module en_latch (
  input  logic d,
  input  logic g_n,
  output logic q
);

  // NOTE: a level-sensitive latch is intended here, so always_latch is used.
  // It states that intent to the tools. An always_comb block that left q
  // unassigned on some path would infer the same latch by accident.
  always_latch begin
    if (!g_n) begin
      q <= d;
    end
  end

endmodule

// File: rtl/int_clk_gate.sv
// ---------------------------------------------------------------------------
// int_clk_gate
// Latch-based integrated clock gate. The enable is captured by a latch that
// is transparent while clk_in is low. The latch output is then ANDed with
// clk_in. While clk_in is high the latch is closed, so a change on en cannot
// shorten a pulse or add one. Every high phase of out_sig is therefore a
// complete clk_in high phase.
//
// Reset acts only through the enable path. While rst is high, the latch loads
// 0 during each low phase, so the gated clock stops cleanly after the pulse
// that is already in progress.
//
// Ports
//   clk_in   in  1  source clock
//   rst      in  1  synchronous active-high reset (gates the latch input)
//   en       in  1  functional clock enable, synchronous to clk_in
//   out_sig  out 1  gated clock = clk_in & lat_o
//   lat_o    out 1  enable latch state, for observability
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module int_clk_gate (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  output logic out_sig,
  output logic lat_o
);

  logic latch_d;

  // Reset forces the latch to load 0. It therefore takes effect at the same
  // latch-closing edge as a normal enable change.
  assign latch_d = en & ~rst;

  en_latch u_en_latch (
    .d   (latch_d),
    .g_n (clk_in),
    .q   (lat_o)
  );

  // Nothing may sit between the latch and this AND gate. Any extra logic here
  // could reopen the path for glitches on the gated clock.
  assign out_sig = clk_in & lat_o;

endmodule

// File: tb/tb_int_clk_gate.sv
// ---------------------------------------------------------------------------
// tb_int_clk_gate
// Directed bench for int_clk_gate. The clock period is 20 units: clk_in starts
// at 0 and rises at 10, 30, 50, and so on. Outputs are sampled a little away
// from the clock edges. Expected values are worked out by hand from the
// latch-then-AND behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_int_clk_gate;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  logic en     = 1'b0;
  logic out_sig;
  logic lat_o;

  int vectors     = 0;
  int miscompares = 0;

  int_clk_gate dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .out_sig (out_sig),
    .lat_o   (lat_o)
  );

  always #10 clk_in = ~clk_in;

  task automatic check(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s @%0t: observed=%b expected=%b", tag, $time, observed, expected);
    end
  endtask

  // Advance to an absolute simulation time.
  task automatic at(input longint unsigned t);
    if ($time < t) #(t - $time);
  endtask

  initial begin
    // Power-up: clk_in low, en low, so the transparent latch shows 0 at once.
    at(1);
    check("pwr_lat", lat_o, 1'b0);
    check("pwr_out", out_sig, 1'b0);

    // Enable raised in the middle of the 10-20 high phase.
    at(12);  check("s1_no_pulse_10", out_sig, 1'b0);
    at(15);  en = 1'b1;
    at(16);  check("s1_lat_held", lat_o, 1'b0);
             check("s1_out_16", out_sig, 1'b0);
    at(21);  check("s1_lat_rise", lat_o, 1'b1);
             check("s1_out_low_ph", out_sig, 1'b0);
    at(31);  check("s1_pulse_30", out_sig, 1'b1);
    at(41);  check("s1_out_40", out_sig, 1'b0);
    at(51);  check("s1_pulse_50", out_sig, 1'b1);

    // Enable dropped in the middle of the 50-60 high phase: pulse runs full width.
    at(55);  en = 1'b0;
    at(56);  check("s2_pulse_cont", out_sig, 1'b1);
    at(59);  check("s2_pulse_full", out_sig, 1'b1);
             check("s2_lat_held", lat_o, 1'b1);
    at(61);  check("s2_lat_fall", lat_o, 1'b0);

    // Enable raised exactly on the rising edge at 70: the value before the edge is used.
    @(posedge clk_in);
    en = 1'b1;
    at(71);  check("s3_no_pulse_70", out_sig, 1'b0);
             check("s3_lat_71", lat_o, 1'b0);
    at(81);  check("s3_lat_rise", lat_o, 1'b1);
    at(91);  check("s3_pulse_90", out_sig, 1'b1);
    at(111); check("s3_pulse_110", out_sig, 1'b1);

    // Glitch check: lat_o was 1 before 130. Toggle en inside the 130-140 high phase.
    at(132); en = 1'b0;
    at(133); check("g1_out_133", out_sig, 1'b1);
    at(134); en = 1'b1;
    at(135); check("g1_out_135", out_sig, 1'b1);
    at(136); en = 1'b0;
    at(137); check("g1_out_137", out_sig, 1'b1);
    at(141); check("g1_lat_fall", lat_o, 1'b0);
    // lat_o is 0 before 150. Toggle en inside the 150-160 high phase.
    at(152); en = 1'b1;
    at(153); check("g2_out_153", out_sig, 1'b0);
    at(154); en = 1'b0;
    at(155); check("g2_out_155", out_sig, 1'b0);
    at(156); en = 1'b1;
    at(157); check("g2_out_157", out_sig, 1'b0);
    at(161); check("g2_lat_rise", lat_o, 1'b1);
    at(171); check("g2_pulse_170", out_sig, 1'b1);

    // Synchronous reset asserted in the middle of the 190-200 pulse, with en held high.
    at(195); rst = 1'b1;
    at(196); check("r_pulse_cont", out_sig, 1'b1);
    at(199); check("r_pulse_full", out_sig, 1'b1);
    at(201); check("r_lat_clear", lat_o, 1'b0);
    at(211); check("r_no_pulse_210", out_sig, 1'b0);
    at(231); check("r_no_pulse_230", out_sig, 1'b0);
    // Release reset in the middle of the 250-260 high phase: pulses resume at 270.
    at(255); rst = 1'b0;
    at(256); check("r_rel_out_256", out_sig, 1'b0);
    at(261); check("r_rel_lat", lat_o, 1'b1);
    at(271); check("r_resume_270", out_sig, 1'b1);

    // Reset asserted exactly on the 290 rising edge: the 290 pulse still runs.
    @(posedge clk_in);
    rst = 1'b1;
    at(291); check("re_pulse_290", out_sig, 1'b1);
    at(301); check("re_lat_clear", lat_o, 1'b0);
    at(311); check("re_no_pulse_310", out_sig, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
